// File: rtl/ssd_bcd_ctrl_if.sv
// Request channel into the BCD display controller: a binary value plus the
// leading-zero blanking option, transferred with a valid/ready handshake.
interface ssd_bcd_ctrl_if #(
  parameter int unsigned DATA_W = 14
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              blank_lz;

  // Producer of display values
  modport master (
    output in_valid,
    output in_data,
    output blank_lz,
    input  in_ready
  );

  // Display controller side
  modport slave (
    input  in_valid,
    input  in_data,
    input  blank_lz,
    output in_ready
  );
endinterface

// File: rtl/ssd_bcd_ctrl.sv
// Binary-to-BCD front-end for the four-digit seven-segment multiplexer.
// Converts an accepted value with a sequential double-dabble engine, then
// encodes all four digits into active-low {g,f,e,d,c,b,a} patterns in one
// cycle so the display never shows a partially converted value.
module ssd_bcd_ctrl #(
  parameter int unsigned DATA_W = 14
) (
  input  logic                clk,
  input  logic                rst,
  ssd_bcd_ctrl_if.slave       in_if,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic [6:0]          seg0,
  output logic [6:0]          seg1,
  output logic [6:0]          seg2,
  output logic [6:0]          seg3
);

  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned N_DIG  = 4;

  localparam logic [DATA_W-1:0] MAX_VAL    = DATA_W'(9999);
  localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(DATA_W - 1);
  localparam logic [SEG_W-1:0]  SEG_BLANK  = 7'b1111111;
  localparam logic [SEG_W-1:0]  SEG_DASH   = 7'b0111111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_ENCODE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_flag_q;
  logic              blz_q;
  logic              ready_q;

  logic              accept_c;
  logic              over_c;
  logic              load_c;
  logic              shift_c;
  logic              encode_c;
  logic [BCD_W-1:0]  bcd_adj_c;
  logic [SEG_W-1:0]  seg_c [N_DIG];

  // Active-low segment pattern for one BCD digit; non-decimal codes blank
  function automatic logic [SEG_W-1:0] seg_of(input logic [NIB_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign accept_c       = (state_q == S_IDLE) && ready_q && in_if.in_valid;
  assign over_c         = in_if.in_data > MAX_VAL;
  assign in_if.in_ready = ready_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = over_c ? S_ENCODE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q == LAST_SHIFT) begin
          state_d = S_ENCODE;
        end
      end
      S_ENCODE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state
  always_comb begin
    load_c   = 1'b0;
    shift_c  = 1'b0;
    encode_c = 1'b0;
    case (state_q)
      S_IDLE:   load_c   = accept_c;
      S_SHIFT:  shift_c  = 1'b1;
      S_ENCODE: encode_c = 1'b1;
      default: begin
        load_c   = 1'b0;
        shift_c  = 1'b0;
        encode_c = 1'b0;
      end
    endcase
  end

  // Add-3 correction per nibble, no carry between nibbles
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < int'(N_DIG); i++) begin
      if (bcd_q[NIB_W*i +: NIB_W] >= 4'd5) begin
        bcd_adj_c[NIB_W*i +: NIB_W] = bcd_q[NIB_W*i +: NIB_W] + 4'd3;
      end
    end
  end

  // Segment patterns for the finished conversion, with leading-zero blanking
  always_comb begin
    logic blank3;
    logic blank2;
    logic blank1;
    blank3 = blz_q  && (bcd_q[15:12] == 4'd0);
    blank2 = blank3 && (bcd_q[11:8]  == 4'd0);
    blank1 = blank2 && (bcd_q[7:4]   == 4'd0);
    seg_c[0] = seg_of(bcd_q[3:0]);
    seg_c[1] = blank1 ? SEG_BLANK : seg_of(bcd_q[7:4]);
    seg_c[2] = blank2 ? SEG_BLANK : seg_of(bcd_q[11:8]);
    seg_c[3] = blank3 ? SEG_BLANK : seg_of(bcd_q[15:12]);
    if (ovf_flag_q) begin
      for (int i = 0; i < int'(N_DIG); i++) begin
        seg_c[i] = SEG_DASH;
      end
    end
  end

  // Conversion registers, handshake state and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      blz_q      <= 1'b0;
      ready_q    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      seg0       <= SEG_BLANK;
      seg1       <= SEG_BLANK;
      seg2       <= SEG_BLANK;
      seg3       <= SEG_BLANK;
    end else begin
      done <= encode_c;

      // ready returns the cycle after the done pulse, so a request that
      // coincides with done is held off for one cycle
      if (done) begin
        ready_q <= 1'b1;
        busy    <= 1'b0;
      end

      if (load_c) begin
        bin_q      <= in_if.in_data;
        blz_q      <= in_if.blank_lz;
        ovf_flag_q <= over_c;
        bcd_q      <= '0;
        cnt_q      <= '0;
        ready_q    <= 1'b0;
        busy       <= 1'b1;
      end

      if (shift_c) begin
        {bcd_q, bin_q} <= {bcd_adj_c, bin_q} << 1;
        cnt_q          <= cnt_q + CNT_W'(1);
      end

      if (encode_c) begin
        seg0 <= seg_c[0];
        seg1 <= seg_c[1];
        seg2 <= seg_c[2];
        seg3 <= seg_c[3];
        ovf  <= ovf_flag_q;
      end
    end
  end

endmodule

// File: tb/tb_ssd_bcd_ctrl.sv
// Self-checking bench for ssd_bcd_ctrl: directed cases plus randomized
// values compared against a decimal-arithmetic display model.
module tb_ssd_bcd_ctrl;

  localparam int unsigned DW = 14;

  logic       clk;
  logic       rst;
  logic       busy;
  logic       done;
  logic       ovf;
  logic [6:0] seg0;
  logic [6:0] seg1;
  logic [6:0] seg2;
  logic [6:0] seg3;
  logic [27:0] segs;

  int n_checks;
  int n_err;

  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000};
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  ssd_bcd_ctrl_if #(.DATA_W(DW)) bus ();

  ssd_bcd_ctrl #(.DATA_W(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .in_if (bus),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .seg0  (seg0),
    .seg1  (seg1),
    .seg2  (seg2),
    .seg3  (seg3)
  );

  assign segs = {seg3, seg2, seg1, seg0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected display from decimal digits of the value
  function automatic logic [27:0] model_segs(input int v, input bit blz);
    int d [4];
    logic [6:0] s [4];
    bit lead;
    if (v > 9999) return {DASH, DASH, DASH, DASH};
    d[0] = v % 10;
    d[1] = (v / 10) % 10;
    d[2] = (v / 100) % 10;
    d[3] = v / 1000;
    lead = blz;
    for (int k = 3; k >= 0; k--) begin
      if (lead && k > 0 && d[k] == 0) s[k] = BLANK;
      else begin
        s[k] = pat[d[k]];
        lead = 1'b0;
      end
    end
    return {s[3], s[2], s[1], s[0]};
  endfunction

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (bus.in_ready !== 1'b1) chk({tag, "_ready_timeout"}, 32'(bus.in_ready), 32'd1);
  endtask

  // Wait for done after an accept at E0; returns edges counted since E0
  task automatic wait_done(input logic [27:0] prev, output int n, output bit held);
    n = 0;
    held = 1'b1;
    while (n < 40 && done !== 1'b1) begin
      if (segs !== prev) held = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_xfer(input int v, input bit blz, input string tag);
    int n;
    bit held;
    logic [27:0] prev;
    @(negedge clk);
    wait_ready(tag);
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(v);
    bus.blank_lz = blz;
    prev = segs;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = DW'($urandom);
    bus.blank_lz = 1'($urandom);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(prev, n, held);
    chk({tag, "_latency"}, 32'(n), (v > 9999) ? 32'd1 : 32'(DW + 1));
    chk({tag, "_segs"}, 32'(segs), 32'(model_segs(v, blz)));
    chk({tag, "_ovf"}, 32'(ovf), 32'(v > 9999));
    chk({tag, "_hold"}, 32'(held), 32'd1);
    chk({tag, "_ready_at_done"}, 32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    int n;
    bit held;
    bit saw_done;
    logic [27:0] prev;

    n_checks = 0;
    n_err    = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_segs", 32'(segs), 32'hFFFFFFF);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    run_xfer(1234, 1'b0, "v1234");
    run_xfer(42, 1'b1, "v42_blz");
    run_xfer(0, 1'b1, "v0_blz");
    run_xfer(0, 1'b0, "v0");
    run_xfer(9999, 1'b0, "v9999");
    run_xfer(10000, 1'b0, "v10000");
    run_xfer(16383, 1'b1, "v16383");
    run_xfer(105, 1'b1, "v105_blz");

    // valid held high: 5 accepted, 6 ignored while busy, then accepted
    @(negedge clk);
    wait_ready("hold");
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(5);
    bus.blank_lz = 1'b0;
    prev = segs;
    @(posedge clk);
    #1;
    bus.in_data = DW'(6);
    chk("hold_busy5", 32'(busy), 32'd1);
    wait_done(prev, n, held);
    chk("hold_lat5", 32'(n), 32'(DW + 1));
    chk("hold_segs5", 32'(segs), 32'(model_segs(5, 1'b0)));
    chk("hold_hold5", 32'(held), 32'd1);
    chk("hold_ready_at_done", 32'(bus.in_ready), 32'd0);
    prev = segs;
    @(posedge clk);
    #1;
    chk("hold_ready_after", 32'(bus.in_ready), 32'd1);
    chk("hold_busy_after", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("hold_busy6", 32'(busy), 32'd1);
    wait_done(prev, n, held);
    chk("hold_lat6", 32'(n), 32'(DW + 1));
    chk("hold_segs6", 32'(segs), 32'(model_segs(6, 1'b0)));
    chk("hold_hold6", 32'(held), 32'd1);

    // reset at E7 of a conversion aborts it
    @(negedge clk);
    wait_ready("abort");
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(8765);
    bus.blank_lz = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_segs", 32'(segs), 32'hFFFFFFF);
    chk("abort_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    run_xfer(8765, 1'b0, "v8765");

    // randomized values, biased toward boundaries
    for (int t = 0; t < 40; t++) begin
      int v;
      int gap;
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 16383));
        1:       v = int'($urandom_range(9990, 10010));
        2:       v = int'($urandom_range(0, 99));
        default: v = int'($urandom_range(0, 9999));
      endcase
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(posedge clk);
      run_xfer(v, 1'($urandom), $sformatf("rnd%0d_v%0d", t, v));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ssd_bcd_ctrl.md
Name: ssd_bcd_ctrl

Overview:
Sequencing front-end for the four-digit seven-segment display multiplexer. It accepts a binary value over a valid/ready handshake and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine. It encodes the digits to active-low segment patterns and drives the seg0..seg3 inputs of the display multiplexer. All four digit outputs update together in a single cycle, so the display never shows a partially converted value.

Parameters:
DATA_W, 14, width of in_data; legal range 14..16; conversion takes DATA_W shift cycles.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_valid  in  1  value request
in_ready  out  1  block can accept a value
in_data  in  DATA_W  unsigned binary value to display
blank_lz  in  1  1 = blank leading zeros; sampled at accept
busy  out  1  conversion in progress (equals ~in_ready)
done  out  1  one-cycle pulse when seg0..seg3 update
ovf  out  1  registered; 1 while the displayed value is the overflow pattern
seg0  out  7  digit 0 pattern (least significant, rightmost)
seg1  out  7  digit 1 pattern
seg2  out  7  digit 2 pattern
seg3  out  7  digit 3 pattern (most significant)

Behaviour:
- Single clock, clk. rst is synchronous and active-high, and is sampled only on the rising edge of clk.
- Segment format is {g,f,e,d,c,b,a}, active-low.
  - Digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Blank = 1111111. Dash = 0111111.
- Reset values: seg0..seg3 = 1111111, done=0, ovf=0, in_ready=1, busy=0; state = IDLE. Internal shift and BCD registers are cleared.
- FSM states: IDLE, SHIFT, ENCODE.
  - IDLE: in_ready=1. On in_valid&in_ready at edge E0:
    - latch in_data and blank_lz;
    - if in_data > 9999, set the overflow flag and go to ENCODE;
    - otherwise clear the 16-bit BCD accumulator, load the binary shift register, and go to SHIFT with the shift counter at 0.
  - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1. Go to ENCODE after exactly DATA_W shifts.
  - ENCODE: at the next edge, register all four seg outputs and ovf, pulse done for one cycle, and return to IDLE.
- Latency:
  - Normal value: outputs and done change at edge E0+DATA_W+1 (E15 for the default). in_ready is high again in the cycle following that edge.
  - Overflow value: outputs and done change at E1.
- Overflow: all four digits show Dash, ovf=1. The value 9999 exactly is not an overflow.
- Leading-zero blanking, applied when the latched blank_lz=1:
  - digit3 is Blank if it is 0;
  - digit2 is Blank if it and digit3 are 0;
  - digit1 is Blank if it, digit2 and digit3 are all 0;
  - digit0 is never blanked.
  - When blank_lz=0, all four digits are always shown.
- While busy: in_valid is ignored and no request is queued. in_data and blank_lz changes have no effect. seg0..seg3 hold their previous values.
- A request presented in the same cycle that done pulses is not accepted, because in_ready is 0 in that cycle. It is accepted in the following cycle.
- rst asserted in any state, including mid-SHIFT, aborts the conversion and restores all reset values at that edge. No done pulse is generated.
- Widths: the BCD accumulator is 16 bits and the add-3 is applied per nibble with no carry between nibbles. The shift counter is ceil(log2(DATA_W+1)) bits.

Test Plan:
- Reset, then accept 1234 (blank_lz=0) -> done at E15; seg3=1111001, seg2=0100100, seg1=0110000, seg0=0011001; ovf=0; busy high for E1..E15.
- Accept 42 with blank_lz=1 -> seg3=seg2=1111111, seg1=0011001, seg0=0100100. Accept 0 with blank_lz=1 -> seg3..seg1 blank, seg0=1000000. Accept 0 with blank_lz=0 -> all four digits 1000000.
- Accept 9999 -> all digits 0010000, ovf=0. Accept 10000 -> all digits 0111111, ovf=1, done at E1.
- Hold in_valid high continuously with data 5 then 6 -> 5 is accepted, 6 is ignored while busy, and a new accept occurs only in the cycle after done. The outputs never show a partial value between done pulses.
- Assert rst at E7 of a conversion of 8765 -> seg0..seg3=1111111, in_ready=1, no done pulse. A subsequent accept of 8765 completes normally: 0000000, 1111000, 0000010, 0010010 for seg3..seg0.
